shiftreg_tap_param: RTL and testbench
=====================================

// Module: shiftreg_tap_param
// PURPOSE
//  Parametrised multi-stage delay line: WIDTH-bit words shifted through DEPTH stages.
//  Adds shift-enable, synchronous flush, run-time tap select (programmable delay),
//  and fill tracking with a valid flag.
//  Sits in datapaths needing a programmable N-cycle sample delay: FIR taps, pipeline alignment.
// PARAMETERS
//  WIDTH  16  data word width in bits (>=1)
//  DEPTH  8   number of stages (>=2); also the maximum delay in enabled shifts
//  SELW   3   tap-select width; must satisfy 2**SELW >= DEPTH
// PORTS
//  ck       in   1          rising-edge clock
//  reset_n  in   1          asynchronous, active-low reset
//  en       in   1          shift enable; 1 = shift one stage this edge, 0 = hold
//  clr      in   1          synchronous flush of all stages and the fill count
//  din      in   WIDTH      word entering stage 0
//  sel      in   SELW       tap select; dout = stage[sel], i.e. delay of sel+1 enabled shifts
//  dout     out  WIDTH      selected stage content (combinational mux of registered stages)
//  valid    out  1          1 when the selected stage holds a word actually shifted in since reset/clr
//  full     out  1          1 when fill count == DEPTH
//  sel_err  out  1          1 when sel >= DEPTH (combinational)
// BEHAVIOUR
//  - Reset: reset_n=0 asynchronously forces all stages to 0 and fill to 0.
//    Therefore dout=0, valid=0 and full=0; sel_err follows sel. Reset mid-shift discards all data.
//  - Priority at each posedge ck: clr > en > hold.
//  - clr=1: all stages <= 0 and fill <= 0, regardless of en. din is not captured.
//  - en=1, clr=0: stage[0] <= din; stage[k] <= stage[k-1] for k=1..DEPTH-1.
//    fill <= min(fill+1, DEPTH); saturates, no wrap.
//  - en=0, clr=0: stages and fill hold.
//  - Latency: a word presented with en=1 at edge n appears on dout when sel=s after s+1 enabled edges.
//    Disabled cycles stretch wall-clock delay but not stage count.
//  - fill is $clog2(DEPTH+1) bits wide and counts enabled shifts since reset/clr.
//  - valid = (fill > sel) && !sel_err. Recomputed combinationally when sel changes; no pipeline bubble.
//  - sel >= DEPTH: dout clamps to stage[DEPTH-1], sel_err=1, valid=0.
//  - full = (fill == DEPTH). It stays 1 while shifting continues and drops only on clr or reset.
//  - Word at stage[DEPTH-1] is dropped on the next enabled shift. No overflow indication beyond full.
// CONFIGURATION
//  SREG_ALLTAPS_EN defined:
//    extra output taps_flat [WIDTH*DEPTH-1:0], with taps_flat[WIDTH*k +: WIDTH] = stage[k].
//    Intended for parallel FIR tap access; same reset/clr values as the stages.
//  SREG_ALLTAPS_EN undefined:
//    port absent; stages visible only through dout. Behaviour otherwise identical.
// STRUCTURE
//  - Package sreg_pkg: function clog2_f(n) used for the fill width.
//  - Package sreg_pkg: localparam default WIDTH/DEPTH constants shared with consumers.
//  - Stage array: reg [WIDTH-1:0] stage [0:DEPTH-1], updated with a for loop in one
//    always @(posedge ck, negedge reset_n).
//  - One sub-module sreg_fill_ctr: saturating up-counter with inc, clr, async reset_n,
//    and outputs fill and full. The tap mux and valid logic stay in the top level.
// TESTING
//  1. Reset: reset_n=0 mid-stream after 5 shifts -> next cycle dout=0, valid=0, full=0.
//     Release, then en=1, din=16'hA5A5, sel=0 -> after 1 edge dout=16'hA5A5, valid=1.
//  2. Delay: sel=7, push 16'h0001..16'h0008 on consecutive enabled edges -> after 8th edge
//     dout=16'h0001, valid=1, full=1. Earlier, valid=0 while fill<=7.
//  3. Enable gaps: sel=2, push 16'h1111; en=0 for 4 cycles between pushes -> dout=16'h1111
//     only after the 3rd enabled edge; value holds across disabled cycles.
//  4. clr vs en: with full=1, assert clr=1 and en=1 on the same edge, din=16'hFFFF
//     -> all stages 0, fill=0, valid=0; din is not captured.
//  5. Tap sweep: fill=4, sweep sel 0..7 with no clock edges -> dout=stage[sel] each value;
//     valid=1 for sel 0..3, 0 for sel 4..7.
//  6. Out-of-range: DEPTH=6, SELW=3, sel=7 -> sel_err=1, valid=0, dout=stage[5].
//     With SREG_ALLTAPS_EN, taps_flat slices equal stage contents.

Source files
------------

// File: rtl/sreg_pkg.sv
// Shared constants and helpers for the tapped delay line.
// Consumers pick up the default word width, depth and select width from here
// so that producers and consumers of the delay line agree on the geometry.
package sreg_pkg;

   localparam int SREG_WIDTH_DEF = 16;
   localparam int SREG_DEPTH_DEF = 8;
   localparam int SREG_SELW_DEF  = 3;

   // Ceiling log2 for elaboration-time widths; clog2_f(1) = 0, clog2_f(9) = 4.
   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sreg_fill_ctr.sv
// Saturating fill counter for the delay line.
// Counts enabled shifts since reset or flush and stops at DEPTH, so "full"
// stays asserted while the line keeps shifting. Flush wins over increment.
module sreg_fill_ctr
   import sreg_pkg::*;
#(
   parameter int DEPTH = SREG_DEPTH_DEF,
   parameter int FW    = clog2_f(DEPTH + 1)
)(
   input  logic          ck,
   input  logic          reset_n,
   input  logic          inc,
   input  logic          clr,
   output logic [FW-1:0] fill,
   output logic          full
);

   localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

   logic [FW-1:0] fill_q;
   logic [FW-1:0] fill_d;

   // Next count: flush, else saturating increment, else hold.
   always_comb begin
      fill_d = fill_q;
      if (clr) begin
         fill_d = '0;
      end else if (inc && (fill_q != FILL_MAX)) begin
         fill_d = fill_q + FW'(1);
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end

   assign fill = fill_q;
   assign full = (fill_q == FILL_MAX);

endmodule

// File: rtl/shiftreg_tap_param.sv
// Programmable-delay line: WIDTH-bit words shifted through DEPTH stages with
// shift enable, synchronous flush and a run-time tap select.
// dout = stage[sel] gives a delay of sel+1 enabled shifts; out-of-range
// selects clamp to the last stage and raise sel_err.
// Optional feature macro: SREG_ALLTAPS_EN adds taps_flat, a flat view of
// every stage (stage k at taps_flat[WIDTH*k +: WIDTH]) for parallel FIR taps.
module shiftreg_tap_param
   import sreg_pkg::*;
#(
   parameter int WIDTH = SREG_WIDTH_DEF,
   parameter int DEPTH = SREG_DEPTH_DEF,
   parameter int SELW  = SREG_SELW_DEF
)(
   input  logic                   ck,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic                   clr,
   input  logic [WIDTH-1:0]       din,
   input  logic [SELW-1:0]        sel,
   output logic [WIDTH-1:0]       dout,
   output logic                   valid,
   output logic                   full,
   output logic                   sel_err
`ifdef SREG_ALLTAPS_EN
   ,
   output logic [WIDTH*DEPTH-1:0] taps_flat
`endif
);

   localparam int FW = clog2_f(DEPTH + 1);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [FW-1:0]    fill;
   logic [31:0]      sel_ext;
   logic [31:0]      fill_ext;

   // Stage array: flush beats shift; the oldest word falls off the end.
   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else if (clr) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else if (en) begin
         stage_q[0] <= din;
         for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
   end

   sreg_fill_ctr #(
      .DEPTH (DEPTH),
      .FW    (FW)
   ) u_fill_ctr (
      .ck      (ck),
      .reset_n (reset_n),
      .inc     (en),
      .clr     (clr),
      .fill    (fill),
      .full    (full)
   );

   // Compare select and fill on a common width so any SELW/FW pairing works.
   assign sel_ext  = 32'(sel);
   assign fill_ext = 32'(fill);
   assign sel_err  = (sel_ext >= 32'(DEPTH));
   assign valid    = (fill_ext > sel_ext) && !sel_err;

   // Tap mux; an unmatched select falls through to the last stage.
   always_comb begin
      dout = stage_q[DEPTH-1];
      for (int k = 0; k < DEPTH; k++) begin
         if (sel_ext == 32'(k)) dout = stage_q[k];
      end
   end

`ifdef SREG_ALLTAPS_EN
   for (genvar g = 0; g < DEPTH; g++) begin : g_taps
      assign taps_flat[WIDTH*g +: WIDTH] = stage_q[g];
   end
`endif

endmodule

// File: tb/tb_shiftreg_tap_param.sv
// Self-checking bench for shiftreg_tap_param: a DEPTH=8 instance for the main
// checks and a DEPTH=6 instance for out-of-range tap selects.
module tb_shiftreg_tap_param;

   logic        ck;
   logic        reset_n;
   logic        en, clr;
   logic [15:0] din;
   logic [2:0]  sel;
   logic [15:0] dout;
   logic        valid, full, sel_err;

   logic        en6, clr6;
   logic [15:0] din6;
   logic [2:0]  sel6;
   logic [15:0] dout6;
   logic        valid6, full6, sel_err6;

`ifdef SREG_ALLTAPS_EN
   logic [127:0] taps_flat;
   logic [95:0]  taps_flat6;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   shiftreg_tap_param #(.WIDTH(16), .DEPTH(8), .SELW(3)) dut (
      .ck        (ck),
      .reset_n   (reset_n),
      .en        (en),
      .clr       (clr),
      .din       (din),
      .sel       (sel),
      .dout      (dout),
      .valid     (valid),
      .full      (full),
      .sel_err   (sel_err)
`ifdef SREG_ALLTAPS_EN
      ,
      .taps_flat (taps_flat)
`endif
   );

   shiftreg_tap_param #(.WIDTH(16), .DEPTH(6), .SELW(3)) dut6 (
      .ck        (ck),
      .reset_n   (reset_n),
      .en        (en6),
      .clr       (clr6),
      .din       (din6),
      .sel       (sel6),
      .dout      (dout6),
      .valid     (valid6),
      .full      (full6),
      .sel_err   (sel_err6)
`ifdef SREG_ALLTAPS_EN
      ,
      .taps_flat (taps_flat6)
`endif
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   typedef struct {
      logic        en;
      logic        clr;
      logic [15:0] din;
      logic [2:0]  sel;
      logic [15:0] exp_dout;
      logic        exp_valid;
      logic        exp_full;
   } vec_t;

   vec_t        vecs [15];
   logic [15:0] sb_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic drive(input logic e, input logic c, input logic [15:0] d);
      en  = e;
      clr = c;
      din = d;
   endtask

   initial begin
      logic [15:0] w;

      // Enable-gap sequence at tap 2, ending with a tap change at rest.
      vecs[0]  = '{1'b0, 1'b1, 16'h0000, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 16'h1111, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 16'h2222, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 16'h2222, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 16'h2222, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 16'h2222, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 16'h2222, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 16'h3333, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 16'h3333, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 16'h3333, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 16'h3333, 3'd2, 16'h0000, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 16'h3333, 3'd2, 16'h1111, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 16'h4444, 3'd2, 16'h1111, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 16'h4444, 3'd2, 16'h1111, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 16'h4444, 3'd0, 16'h3333, 1'b1, 1'b0};

      reset_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0000);
      sel  = 3'd0;
      en6  = 1'b0;
      clr6 = 1'b0;
      din6 = 16'h0000;
      sel6 = 3'd0;

      // Reset state.
      #2;
      chk("rst_dout", dout, 0);
      chk("rst_valid", valid, 0);
      chk("rst_full", full, 0);
      chk("rst_sel_err", sel_err, 0);
      tick();
      reset_n = 1'b1;

      // Asynchronous reset in the middle of a stream.
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 1'b0, 16'(i));
         tick();
      end
      chk("pre_rst_dout", dout, 16'h0005);
      drive(1'b0, 1'b0, 16'h0000);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_dout", dout, 0);
      chk("async_rst_valid", valid, 0);
      tick();
      chk("midrst_dout", dout, 0);
      chk("midrst_valid", valid, 0);
      chk("midrst_full", full, 0);
      reset_n = 1'b1;
      sel = 3'd4;
      #1;
      chk("postrst_tap4", dout, 0);
      sel = 3'd0;
      drive(1'b1, 1'b0, 16'hA5A5);
      tick();
      chk("first_dout", dout, 16'hA5A5);
      chk("first_valid", valid, 1);
      chk("first_full", full, 0);

      // Vector table.
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].en, vecs[i].clr, vecs[i].din);
         sel = vecs[i].sel;
         tick();
         chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
         chk($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
         chk($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
      end

      // Full-depth delay at tap 7, scoreboarded past saturation.
      drive(1'b0, 1'b1, 16'h0000);
      tick();
      sel = 3'd7;
      for (int i = 1; i <= 12; i++) begin
         w = 16'(i);
         drive(1'b1, 1'b0, w);
         sb_q.push_back(w);
         tick();
         if (sb_q.size() == 8) begin
            chk($sformatf("delay%0d_dout", i), dout, sb_q.pop_front());
            chk($sformatf("delay%0d_valid", i), valid, 1);
            chk($sformatf("delay%0d_full", i), full, 1);
         end else begin
            chk($sformatf("delay%0d_valid", i), valid, 0);
            chk($sformatf("delay%0d_full", i), full, 0);
         end
      end
      chk("sb_depth", sb_q.size(), 7);

      // Flush beats enable on the same edge; din is dropped.
      drive(1'b1, 1'b1, 16'hFFFF);
      sel = 3'd0;
      tick();
      chk("clr_dout0", dout, 0);
      chk("clr_valid", valid, 0);
      chk("clr_full", full, 0);
      sel = 3'd7;
      #1;
      chk("clr_dout7", dout, 0);
      drive(1'b0, 1'b0, 16'h0000);
      sel = 3'd0;
      tick();
      chk("clr_nocapture", dout, 0);

      // Tap sweep at fill 4 with no clock edges.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, 16'hC000 + 16'(i));
         tick();
      end
      drive(1'b0, 1'b0, 16'h0000);
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         #1;
         chk($sformatf("sweep%0d_dout", s), dout, (s < 4) ? (16'hC004 - 16'(s)) : 16'h0000);
         chk($sformatf("sweep%0d_valid", s), valid, (s < 4) ? 1 : 0);
         chk($sformatf("sweep%0d_err", s), sel_err, 0);
      end

      // Out-of-range select on the 6-deep line.
      for (int i = 1; i <= 6; i++) begin
         en6  = 1'b1;
         din6 = 16'h6000 + 16'(i);
         tick();
      end
      en6  = 1'b0;
      sel6 = 3'd7;
      #1;
      chk("oor_err", sel_err6, 1);
      chk("oor_valid", valid6, 0);
      chk("oor_dout", dout6, 16'h6001);
      chk("oor_full", full6, 1);
      sel6 = 3'd6;
      #1;
      chk("oor6_err", sel_err6, 1);
      chk("oor6_dout", dout6, 16'h6001);
      sel6 = 3'd5;
      #1;
      chk("last_err", sel_err6, 0);
      chk("last_valid", valid6, 1);
      chk("last_dout", dout6, 16'h6001);
      en6  = 1'b1;
      din6 = 16'h6007;
      sel6 = 3'd7;
      tick();
      en6 = 1'b0;
      chk("oor_shift_dout", dout6, 16'h6002);
      chk("oor_shift_full", full6, 1);
`ifdef SREG_ALLTAPS_EN
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("taps6_%0d", k), taps_flat6[16*k +: 16], 16'h6007 - 16'(k));
      end
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("taps_%0d", k), taps_flat[16*k +: 16], (k < 4) ? (16'hC004 - 16'(k)) : 16'h0000);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
